uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame.sv | 146 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
    $error("uart_tx_frame: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  logic baud_last;
  assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

  // NOTE: every register here, tx_out included, is written with <= so all
  // next-state decisions read the values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_out    <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (tx_valid) begin
            shift_reg <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
            state    <= START;
            tx_out   <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= DATA;
            tx_out   <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state  <= PARITY;
              tx_out <= parity_bit;
`else
              state  <= STOP;
              tx_out <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              // shift_reg[1] becomes shift_reg[0] at this same edge.
              tx_out  <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= STOP;
            tx_out   <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          tx_out <= 1'b1;
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
              bit_cnt  <= '0;
              state    <= IDLE;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          tx_out   <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: one 1-stop/even instance, one 2-stop/odd instance.
module tb_uart_tx_frame;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_a, valid_b;
  logic [7:0] data_a, data_b;
  logic       ready_a, out_a, busy_a, done_a;
  logic       ready_b, out_b, busy_b, done_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut_a (
    .clk(clk), .reset(reset), .tx_valid(valid_a), .tx_data(data_a),
    .tx_ready(ready_a), .tx_out(out_a), .tx_busy(busy_a), .tx_done(done_a)
  );

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) u_dut_b (
    .clk(clk), .reset(reset), .tx_valid(valid_b), .tx_data(data_b),
    .tx_ready(ready_b), .tx_out(out_b), .tx_busy(busy_b), .tx_done(done_b)
  );

  // order: serial data levels as sent, first-sent bit in the MSB.
  typedef struct {
    bit         sel;
    logic [7:0] data;
    logic [7:0] order;
    logic       par_even;
    int         inject_at;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin valid_b = v; data_b = d; end
    else     begin valid_a = v; data_a = d; end
  endtask

  function automatic logic line_of(input bit sel);
    return sel ? out_b : out_a;
  endfunction
  function automatic logic ready_of(input bit sel);
    return sel ? ready_b : ready_a;
  endfunction
  function automatic logic busy_of(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction
  function automatic logic done_of(input bit sel);
    return sel ? done_b : done_a;
  endfunction

  // Handshake on the next edge, then check every cycle of the frame and the done cycle.
  task automatic run_frame(input bit sel, input logic [7:0] d, input logic [7:0] order,
                           input logic par_even, input int inject_at, input bit hold,
                           input string name);
    logic lv[12];
    int   nb;
    nb = 1 + 8 + PAR_BITS + (sel ? 2 : 1);
    for (int i = 0; i < 12; i++) lv[i] = 1'b1;
    lv[0] = 1'b0;
    for (int i = 1; i <= 8; i++) lv[i] = order[8-i];
    if (PAR_BITS == 1) lv[9] = sel ? ~par_even : par_even;
    drive(sel, 1'b1, d);
    step();
    if (!hold) drive(sel, 1'b0, d);
    for (int c = 0; c < nb * CPB; c++) begin
      check({name, " line"}, line_of(sel), lv[c / CPB]);
      check({name, " ready"}, ready_of(sel), 0);
      check({name, " busy"}, busy_of(sel), 1);
      check({name, " done early"}, done_of(sel), 0);
      if (c == inject_at) drive(sel, 1'b1, 8'hFF);
      else if (inject_at >= 0 && c == inject_at + 1) drive(sel, 1'b0, 8'hFF);
      step();
    end
    check({name, " done"}, done_of(sel), 1);
    check({name, " ready after"}, ready_of(sel), 1);
    check({name, " busy after"}, busy_of(sel), 0);
    check({name, " line after"}, line_of(sel), 1);
  endtask

  task automatic idle_check(input bit sel, input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      step();
      check({name, " idle line"}, line_of(sel), 1);
      check({name, " idle ready"}, ready_of(sel), 1);
      check({name, " idle done"}, done_of(sel), 0);
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{sel: 1'b0, data: 8'hA5, order: 8'hA5, par_even: 1'b0, inject_at: -1};
    vecs[1] = '{sel: 1'b0, data: 8'h07, order: 8'hE0, par_even: 1'b1, inject_at: -1};
    vecs[2] = '{sel: 1'b1, data: 8'h81, order: 8'h81, par_even: 1'b0, inject_at: -1};
    vecs[3] = '{sel: 1'b0, data: 8'h00, order: 8'h00, par_even: 1'b0, inject_at: 10};
    vecs[4] = '{sel: 1'b1, data: 8'hA5, order: 8'hA5, par_even: 1'b0, inject_at: -1};
    vecs[5] = '{sel: 1'b1, data: 8'h07, order: 8'hE0, par_even: 1'b1, inject_at: 20};

    reset = 1'b1;
    valid_a = 1'b0; data_a = 8'h00;
    valid_b = 1'b0; data_b = 8'h00;
    repeat (3) step();
    check("reset line a", out_a, 1);
    check("reset ready a", ready_a, 1);
    check("reset busy a", busy_a, 0);
    check("reset done a", done_a, 0);
    check("reset line b", out_b, 1);
    check("reset ready b", ready_b, 1);
    reset = 1'b0;

    idle_check(1'b0, 12, "no valid");

    foreach (vecs[i]) begin
      run_frame(vecs[i].sel, vecs[i].data, vecs[i].order, vecs[i].par_even,
                vecs[i].inject_at, 1'b0, $sformatf("vec%0d", i));
      idle_check(vecs[i].sel, 6, $sformatf("vec%0d", i));
    end

    // Back-to-back with tx_valid held: 0xAA is taken on the edge that ends the done cycle.
    run_frame(1'b0, 8'h55, 8'hAA, 1'b0, -1, 1'b1, "b2b first");
    data_a = 8'hAA;
    run_frame(1'b0, 8'hAA, 8'h55, 1'b0, -1, 1'b0, "b2b second");
    idle_check(1'b0, 6, "b2b");

    // Reset in the middle of data bit 3 of 0x00.
    drive(1'b0, 1'b1, 8'h00);
    step();
    drive(1'b0, 1'b0, 8'h00);
    repeat (17) step();
    check("pre-reset line", out_a, 0);
    check("pre-reset ready", ready_a, 0);
    reset = 1'b1;
    #1;
    check("async reset line", out_a, 1);
    check("async reset ready", ready_a, 1);
    check("async reset busy", busy_a, 0);
    step();
    reset = 1'b0;
    idle_check(1'b0, 3, "post reset");
    run_frame(1'b0, 8'h3C, 8'h3C, 1'b0, -1, 1'b0, "after reset");
    idle_check(1'b0, 4, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
